// File: rtl/registered_pipeline_if.sv
// Handshake bundle for registered_pipeline: upstream push, downstream pop,
// synchronous flush request and the registered occupancy count.
interface registered_pipeline_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) ();

  localparam int CountWidth = $clog2(DEPTH + 1);

  logic                  i_valid;
  logic                  o_ready;
  logic [WIDTH-1:0]      i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [WIDTH-1:0]      o_data;
  logic                  i_flush;
  logic [CountWidth-1:0] o_count;

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_ready,
    input  i_flush,
    output o_ready,
    output o_valid,
    output o_data,
    output o_count
  );

  modport master (
    output i_valid,
    output i_data,
    output i_ready,
    output i_flush,
    input  o_ready,
    input  o_valid,
    input  o_data,
    input  o_count
  );

endinterface

// File: rtl/registered_pipeline.sv
// Elastic register pipeline: DEPTH stages with per-stage valid bits, bubble
// collapsing under backpressure, synchronous flush and a registered occupancy count.
module registered_pipeline #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  registered_pipeline_if.slave bus
);

  localparam int CountWidth = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      stageValid_q;
  logic [DEPTH-1:0]      stageValid_d;
  logic [WIDTH-1:0]      stageData_q [DEPTH];
  logic [WIDTH-1:0]      stageData_d [DEPTH];
  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;

  logic [DEPTH-1:0]      stageRdy;
  logic                  readyChain;
  logic                  inReady;
  logic                  inAccept;
  logic [DEPTH-1:0]      srcValid;
  logic [WIDTH-1:0]      srcData [DEPTH];

  // A stage may load when it, or any stage between it and the output, is a bubble.
  always_comb begin
    stageRdy   = '0;
    readyChain = bus.i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      readyChain  = readyChain || !stageValid_q[k];
      stageRdy[k] = readyChain;
    end
  end

  assign inReady  = stageRdy[0] && !bus.i_flush;
  assign inAccept = bus.i_valid && inReady;

  always_comb begin
    srcValid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      srcData[k] = '0;
    end
    srcValid[0] = inAccept;
    srcData[0]  = bus.i_data;
    for (int k = 1; k < DEPTH; k++) begin
      srcValid[k] = stageValid_q[k-1];
      srcData[k]  = stageData_q[k-1];
    end
  end

  // Flush drops every valid bit but leaves data registers untouched.
  always_comb begin
    stageValid_d = stageValid_q;
    stageData_d  = stageData_q;
    count_d      = '0;
    if (bus.i_flush) begin
      stageValid_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (stageRdy[k]) begin
          stageValid_d[k] = srcValid[k];
          if (srcValid[k]) begin
            stageData_d[k] = srcData[k];
          end
        end
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CountWidth'(stageValid_d[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stageValid_q <= '0;
      count_q      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stageData_q[k] <= '0;
      end
    end else begin
      stageValid_q <= stageValid_d;
      stageData_q  <= stageData_d;
      count_q      <= count_d;
    end
  end

  assign bus.o_ready = inReady;
  assign bus.o_valid = stageValid_q[DEPTH-1];
  assign bus.o_data  = stageData_q[DEPTH-1];
  assign bus.o_count = count_q;

endmodule

// File: tb/tb_registered_pipeline.sv
// Directed bench for registered_pipeline: a DEPTH=3/WIDTH=32 instance checked every
// cycle against a word-position queue model, plus a DEPTH=1/WIDTH=8 instance.
module tb_registered_pipeline;

  localparam int WideD = 3;

  logic clock = 1'b0;
  logic resetN;

  always #5 clock = ~clock;

  registered_pipeline_if #(.WIDTH(32), .DEPTH(3)) busWide ();
  registered_pipeline_if #(.WIDTH(8),  .DEPTH(1)) busNarrow ();

  registered_pipeline #(.WIDTH(32), .DEPTH(3)) dutWide (
    .i_clk   (clock),
    .i_rst_n (resetN),
    .bus     (busWide)
  );

  registered_pipeline #(.WIDTH(8), .DEPTH(1)) dutNarrow (
    .i_clk   (clock),
    .i_rst_n (resetN),
    .bus     (busNarrow)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Each call spans one cycle: drive just after the edge, return at the falling edge.
  task automatic applyStimulus(input int target, input logic rn, input logic v,
                               input logic [31:0] d, input logic r, input logic f);
    @(posedge clock);
    #1;
    resetN = rn;
    if (target == 0) begin
      busWide.i_valid   = v;
      busWide.i_data    = d;
      busWide.i_ready   = r;
      busWide.i_flush   = f;
      busNarrow.i_valid = 1'b0;
      busNarrow.i_data  = 8'h00;
      busNarrow.i_ready = 1'b0;
      busNarrow.i_flush = 1'b0;
    end else begin
      busNarrow.i_valid = v;
      busNarrow.i_data  = d[7:0];
      busNarrow.i_ready = r;
      busNarrow.i_flush = f;
      busWide.i_valid   = 1'b0;
      busWide.i_data    = 32'h0;
      busWide.i_ready   = 1'b0;
      busWide.i_flush   = 1'b0;
    end
    @(negedge clock);
  endtask

  // Model: queue of words in acceptance order with their stage index; each word
  // moves one stage forward unless blocked by the word ahead of it.
  typedef struct {
    logic [31:0] data;
    int          pos;
  } item_t;

  item_t mq[$];
  int    np[$];
  bit    modelOn = 1'b0;
  bit    modelAccept;
  bit    modelValid;

  function automatic void planMoves(input logic downReady);
    np.delete();
    for (int i = 0; i < mq.size(); i++) begin
      int lim;
      lim = (i == 0) ? (WideD - 1 + (downReady ? 1 : 0)) : (np[i-1] - 1);
      np.push_back((mq[i].pos + 1 < lim) ? (mq[i].pos + 1) : lim);
    end
  endfunction

  function automatic bit modelReady(input logic flush);
    return !flush && (np.size() == 0 || np[np.size()-1] >= 1);
  endfunction

  always @(posedge clock) begin
    if (resetN !== 1'b1) begin
      mq.delete();
      modelOn = 1'b1;
    end else if (modelOn) begin
      planMoves(busWide.i_ready);
      modelAccept = busWide.i_valid && modelReady(busWide.i_flush);
      for (int i = 0; i < mq.size(); i++) begin
        mq[i].pos = np[i];
      end
      if (mq.size() > 0 && mq[0].pos == WideD) begin
        void'(mq.pop_front());
      end
      if (busWide.i_flush) begin
        mq.delete();
      end
      if (modelAccept) begin
        mq.push_back('{data: busWide.i_data, pos: 0});
      end
    end
  end

  always @(negedge clock) begin
    if (modelOn) begin
      planMoves(busWide.i_ready);
      modelValid = mq.size() > 0 && mq[0].pos == WideD - 1;
      checkOutput("model o_ready", 64'(busWide.o_ready), 64'(modelReady(busWide.i_flush)));
      checkOutput("model o_valid", 64'(busWide.o_valid), 64'(modelValid));
      checkOutput("model o_count", 64'(busWide.o_count), 64'(mq.size()));
      if (modelValid) begin
        checkOutput("model o_data", 64'(busWide.o_data), 64'(mq[0].data));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN            = 1'b0;
    busWide.i_valid   = 1'b1;
    busWide.i_data    = 32'hFFFF_FFFF;
    busWide.i_ready   = 1'b0;
    busWide.i_flush   = 1'b0;
    busNarrow.i_valid = 1'b0;
    busNarrow.i_data  = 8'h00;
    busNarrow.i_ready = 1'b0;
    busNarrow.i_flush = 1'b0;

    // Reset held two cycles while a word is offered.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    checkOutput("reset o_valid", 64'(busWide.o_valid), 64'(0));
    checkOutput("reset o_data", 64'(busWide.o_data), 64'(0));
    checkOutput("reset o_count", 64'(busWide.o_count), 64'(0));
    checkOutput("reset narrow o_data", 64'(busNarrow.o_data), 64'(0));
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    checkOutput("reset2 o_data", 64'(busWide.o_data), 64'(0));
    applyStimulus(0, 1, 0, 32'h0, 0, 0);
    checkOutput("release o_ready", 64'(busWide.o_ready), 64'(1));
    checkOutput("release o_valid", 64'(busWide.o_valid), 64'(0));
    checkOutput("release o_count", 64'(busWide.o_count), 64'(0));
    checkOutput("release narrow o_ready", 64'(busNarrow.o_ready), 64'(1));
    checkOutput("release narrow o_count", 64'(busNarrow.o_count), 64'(0));

    // Streaming with three-cycle latency.
    applyStimulus(0, 1, 1, 32'h1, 1, 0);
    checkOutput("stream accept", 64'(busWide.o_ready), 64'(1));
    applyStimulus(0, 1, 1, 32'h2, 1, 0);
    applyStimulus(0, 1, 1, 32'h3, 1, 0);
    checkOutput("stream latency o_valid", 64'(busWide.o_valid), 64'(0));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("stream c3 o_valid", 64'(busWide.o_valid), 64'(1));
    checkOutput("stream c3 o_data", 64'(busWide.o_data), 64'(32'h1));
    checkOutput("stream peak o_count", 64'(busWide.o_count), 64'(3));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("stream c4 o_data", 64'(busWide.o_data), 64'(32'h2));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("stream c5 o_data", 64'(busWide.o_data), 64'(32'h3));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("stream drained o_valid", 64'(busWide.o_valid), 64'(0));

    // Backpressure fill then drain with a simultaneous push.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 1, 32'hA + 32'(i), 0, 0);
      checkOutput("fill o_ready", 64'(busWide.o_ready), (i < 3) ? 64'(1) : 64'(0));
    end
    checkOutput("fill o_count", 64'(busWide.o_count), 64'(3));
    applyStimulus(0, 1, 1, 32'hD, 1, 0);
    checkOutput("drain push o_ready", 64'(busWide.o_ready), 64'(1));
    checkOutput("drain A", 64'(busWide.o_data), 64'(32'hA));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("drain B", 64'(busWide.o_data), 64'(32'hB));
    checkOutput("push-pop o_count", 64'(busWide.o_count), 64'(3));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("drain C", 64'(busWide.o_data), 64'(32'hC));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("drain D", 64'(busWide.o_data), 64'(32'hD));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("drain empty", 64'(busWide.o_valid), 64'(0));

    // Bubble collapse: the gap closes while downstream stalls.
    applyStimulus(0, 1, 1, 32'h1, 1, 0);
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    applyStimulus(0, 1, 1, 32'h2, 0, 0);
    applyStimulus(0, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 1, 0, 32'h0, 0, 0);
    checkOutput("bubble o_count", 64'(busWide.o_count), 64'(2));
    checkOutput("bubble o_ready", 64'(busWide.o_ready), 64'(1));
    checkOutput("bubble o_data", 64'(busWide.o_data), 64'(32'h1));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("bubble out 1", 64'(busWide.o_data), 64'(32'h1));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("bubble out 2 valid", 64'(busWide.o_valid), 64'(1));
    checkOutput("bubble out 2", 64'(busWide.o_data), 64'(32'h2));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);

    // Flush with a full, stalled pipeline and a word offered.
    applyStimulus(0, 1, 1, 32'h11, 0, 0);
    applyStimulus(0, 1, 1, 32'h22, 0, 0);
    applyStimulus(0, 1, 1, 32'h33, 0, 0);
    applyStimulus(0, 1, 1, 32'h44, 0, 1);
    checkOutput("flush cycle o_ready", 64'(busWide.o_ready), 64'(0));
    checkOutput("flush cycle o_count", 64'(busWide.o_count), 64'(3));
    applyStimulus(0, 1, 1, 32'h55, 0, 0);
    checkOutput("post flush o_valid", 64'(busWide.o_valid), 64'(0));
    checkOutput("post flush o_count", 64'(busWide.o_count), 64'(0));
    checkOutput("post flush o_ready", 64'(busWide.o_ready), 64'(1));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("flush input dropped", 64'(busWide.o_count), 64'(1));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    applyStimulus(0, 1, 0, 32'h0, 1, 0);
    checkOutput("after flush word", 64'(busWide.o_data), 64'(32'h55));
    applyStimulus(0, 1, 0, 32'h0, 1, 0);

    // Reset in mid-stream: nothing from before it may emerge.
    applyStimulus(0, 1, 1, 32'h100, 1, 0);
    applyStimulus(0, 1, 1, 32'h101, 1, 0);
    applyStimulus(0, 0, 1, 32'h102, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 1, 0);
      checkOutput("post reset o_valid", 64'(busWide.o_valid), 64'(0));
    end
    applyStimulus(0, 1, 1, 32'h200, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 1, 0);
    end
    checkOutput("post reset word", 64'(busWide.o_data), 64'(32'h200));

    // DEPTH=1, WIDTH=8: one-cycle latency, count toggles 0/1.
    applyStimulus(1, 1, 1, 32'h1, 1, 0);
    checkOutput("d1 accept", 64'(busNarrow.o_ready), 64'(1));
    checkOutput("d1 c0 o_count", 64'(busNarrow.o_count), 64'(0));
    applyStimulus(1, 1, 1, 32'h2, 1, 0);
    checkOutput("d1 latency o_valid", 64'(busNarrow.o_valid), 64'(1));
    checkOutput("d1 o_data 1", 64'(busNarrow.o_data), 64'(8'h1));
    checkOutput("d1 full o_count", 64'(busNarrow.o_count), 64'(1));
    checkOutput("d1 push-pop o_ready", 64'(busNarrow.o_ready), 64'(1));
    applyStimulus(1, 1, 1, 32'h3, 1, 0);
    checkOutput("d1 o_data 2", 64'(busNarrow.o_data), 64'(8'h2));
    applyStimulus(1, 1, 0, 32'h0, 1, 0);
    checkOutput("d1 o_data 3", 64'(busNarrow.o_data), 64'(8'h3));
    applyStimulus(1, 1, 0, 32'h0, 1, 0);
    checkOutput("d1 empty o_count", 64'(busNarrow.o_count), 64'(0));
    applyStimulus(1, 1, 1, 32'h4, 1, 0);
    applyStimulus(1, 1, 0, 32'h0, 1, 0);
    checkOutput("d1 toggle high", 64'(busNarrow.o_count), 64'(1));
    checkOutput("d1 o_data 4", 64'(busNarrow.o_data), 64'(8'h4));
    applyStimulus(1, 1, 0, 32'h0, 1, 0);
    checkOutput("d1 toggle low", 64'(busNarrow.o_count), 64'(0));
    applyStimulus(1, 1, 1, 32'h5, 0, 0);
    applyStimulus(1, 1, 1, 32'h6, 0, 0);
    checkOutput("d1 stall o_ready", 64'(busNarrow.o_ready), 64'(0));
    checkOutput("d1 stall o_data", 64'(busNarrow.o_data), 64'(8'h5));
    applyStimulus(1, 1, 0, 32'h0, 1, 0);
    checkOutput("d1 stall hold", 64'(busNarrow.o_data), 64'(8'h5));
    applyStimulus(1, 1, 0, 32'h0, 1, 0);
    checkOutput("d1 drop 6", 64'(busNarrow.o_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/registered_pipeline.md
# registered_pipeline

Parametrised elastic register pipeline. It carries a WIDTH-bit data word through DEPTH registered stages, with a valid/ready handshake on both sides. It generalises a fixed chain of plain output registers by adding:
- per-stage valid tracking,
- backpressure with bubble collapsing,
- a synchronous flush,
- an occupancy count.

It sits on registered-output paths between blocks wherever a fixed register chain would lose data under downstream stall.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (>= 1)
- DEPTH, 3, number of register stages (>= 1)

Ports:
- i_clk  input  1  clock; all state updates on posedge
- i_rst_n  input  1  reset; one clock, reset is synchronous and active-low
- i_valid  input  1  upstream word valid
- o_ready  output  1  pipeline accepts a word this cycle
- i_data  input  WIDTH  upstream word
- o_valid  output  1  last stage holds a valid word
- i_ready  input  1  downstream accepts a word this cycle
- o_data  output  WIDTH  last-stage word
- i_flush  input  1  discard all held words
- o_count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- **Stage state:** stages 0..DEPTH-1 each hold a data register and a valid bit. Stage 0 is the input end; stage DEPTH-1 drives o_data/o_valid.
- **Stage ready:**
  - rdy[DEPTH] = i_ready.
  - rdy[k] = !valid[k] || rdy[k+1].
  - o_ready = rdy[0] && !i_flush.
  - The ready path is combinational from i_ready to o_ready. This is deliberate, for full throughput.
- **Stage advance:**
  - When rdy[k] is 1, stage k loads the contents of stage k-1: data and valid. For stage 0, the source is i_data and (i_valid && o_ready).
  - When rdy[k] is 0, stage k holds.
  - A bubble (invalid stage) is filled by upstream data even while downstream is stalled, so the pipeline compacts under backpressure.
- **Data registers:** a data register loads only when its stage loads a valid word. Otherwise it holds. o_data reflects the last-stage register regardless of o_valid.
- **Transfers:**
  - Input transfer: i_valid && o_ready at posedge.
  - Output transfer: o_valid && i_ready at posedge.
  - Words leave in strict acceptance order. There is no drop and no duplication except by flush.
- **Flush:**
  - When i_flush=1 at a posedge, all valid bits clear and o_count becomes 0 on the following cycle.
  - o_ready is 0 during the flush cycle, so no input is accepted.
  - An output transfer coinciding with the flush cycle (o_valid && i_ready) still counts as delivered.
  - Data registers are not cleared.
- **o_count:** a registered popcount of the valid bits. It equals (accepted − delivered − flushed) since reset.
- **Reset:** all valid bits = 0, all data registers = 0, o_count = 0. Reset has priority over flush and over all transfers.

## Timing
- **Reset values:** o_valid=0, o_data=0, o_count=0. o_ready = !i_flush from the first cycle after reset, since the pipeline is empty.
- **Latency:** a word accepted in cycle t into an empty, unstalled pipeline appears with o_valid=1 in cycle t+DEPTH.
- **Throughput:** one word per cycle while i_ready=1.
- **Full pipeline:**
  - When all stages are valid and i_ready=0, o_ready=0.
  - If i_ready=1 in the same cycle, o_ready=1: simultaneous push and pop at full occupancy is allowed and o_count is unchanged.
- **Empty pipeline:** o_valid=0, o_ready=1 (absent flush). An i_ready value is ignored.
- **Stall:** words held in stages stay stable (data and valid) while rdy is 0. o_data is stable while o_valid=1 and i_ready=0.
- **Reset mid-operation:** at the posedge with i_rst_n=0, all held words are lost. From the next cycle, outputs show the reset values.
- **Widths:** o_count width is $clog2(DEPTH+1). For DEPTH=1 it is 1 bit, and it must represent the value DEPTH without overflow.

## Test plan
- **Reset:** hold i_rst_n=0 for 2 cycles with i_valid=1 and i_data=0xFFFFFFFF, then release. Required: o_valid=0, o_data=0, o_count=0 during reset and after release; o_ready=1 after release.
- **Streaming:** DEPTH=3, i_ready=1; push 0x1, 0x2, 0x3 in cycles 0–2. Required: o_valid=1 with o_data=0x1, 0x2, 0x3 in cycles 3, 4, 5; o_count peaks at 3.
- **Backpressure fill/drain:** i_ready=0; offer 0xA..0xE on 5 consecutive cycles. Required: only 0xA, 0xB, 0xC accepted; o_ready=0 afterwards; o_count=3. Then set i_ready=1. Required: 0xA, 0xB, 0xC delivered in order on 3 consecutive cycles, and 0xD accepted in the first drain cycle (simultaneous push/pop).
- **Bubble collapse:** DEPTH=3. Push 0x1, idle one cycle, push 0x2, with i_ready=0 from cycle 2. Required: both words reach the last two stages, o_count=2, o_ready=1. Releasing i_ready delivers 0x1 then 0x2 back-to-back.
- **Flush:** with 3 words held and i_valid=1, i_ready=0, pulse i_flush for 1 cycle. Required: o_ready=0 in the flush cycle; next cycle o_valid=0, o_count=0, and the flush-cycle input is not accepted.
- **Reset mid-stream and DEPTH=1:**
  - Drive i_rst_n=0 while streaming. Required: no word from before reset ever appears on the output.
  - Repeat the streaming test with DEPTH=1 and WIDTH=8. Required: latency of 1 cycle; o_count toggles between 0 and 1.
